// File: rtl/uart_pkg.sv
// Shared types, default constants and helpers for the UART receive path.
package uart_pkg;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// Resets to 1 so an idle-high line never looks like an edge out of reset.
module uart_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_bit,
  output logic sync_bit
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '1;
    else        ff <= (ff << 1) | STAGES'(async_bit);
  end

  assign sync_bit = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling 8N1 UART receiver: 3-sample majority vote around mid-bit,
// false-start rejection, and stop-bit framing check with one-clk pulses.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_tick,
  input  logic                 uart_rx_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_data_valid,
  output logic                 rx_frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_LO  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0] T_HI  = TW'(OVERSAMPLE/2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

  logic rxs;

  uart_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_bit (uart_rx_in),
    .sync_bit  (rxs)
  );

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d, err_d;
  logic                 maj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tick_q        <= '0;
      bit_q         <= '0;
      smp_q         <= '0;
      shreg_q       <= '0;
      rx_data_out   <= '0;
      rx_data_valid <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      bit_q         <= bit_d;
      smp_q         <= smp_d;
      shreg_q       <= shreg_d;
      rx_data_out   <= data_d;
      rx_data_valid <= valid_d;
      rx_frame_err  <= err_d;
    end
  end

  // Third sample is the live rxs, so the vote resolves on tick M+1 itself.
  assign maj = maj3(smp_q[1], smp_q[0], rxs);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    shreg_d = shreg_q;
    data_d  = rx_data_out;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (rx_tick) begin
      if (state_q == START || state_q == DATA || state_q == STOP) begin
        tick_d = (tick_q == T_END) ? '0 : tick_q + 1'b1;
        if (tick_q == T_LO || tick_q == T_MID) smp_d = {smp_q[0], rxs};
      end

      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == T_HI && maj) begin
            state_d = IDLE;
            tick_d  = '0;
          end else if (tick_q == T_END) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (tick_q == T_HI) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
          if (tick_q == T_END) begin
            if (bit_q == B_END) begin
              state_d = STOP;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
        STOP: begin
          // Decide early so a start edge right after the stop bit is caught.
          if (tick_q == T_HI) begin
            tick_d = '0;
            if (maj) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (rxs) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: frames, false start, framing error,
// back-to-back frames, mid-frame reset and a single-sample glitch.
`timescale 1ns/1ps
module tb_uart_rx_sampler;

  localparam int OS       = 16;
  localparam int TICK_DIV = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_tick;
  logic       uart_rx_in;
  logic [7:0] rx_data_out;
  logic       rx_data_valid;
  logic       rx_frame_err;

  uart_rx_sampler #(.OVERSAMPLE(OS), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_tick       (rx_tick),
    .uart_rx_in    (uart_rx_in),
    .rx_data_out   (rx_data_out),
    .rx_data_valid (rx_data_valid),
    .rx_frame_err  (rx_frame_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;

  exp_t sbq[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   n_valid = 0;
  int   n_err = 0;

  initial begin
    int div;
    div = 0;
    rx_tick = 1'b0;
    forever begin
      @(negedge clk);
      div = (div == TICK_DIV-1) ? 0 : div + 1;
      rx_tick = (div == 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (rx_data_valid || rx_frame_err)) begin
      exp_t e;
      chk_cnt++;
      if (rx_data_valid) n_valid++;
      if (rx_frame_err)  n_err++;
      if (rx_data_valid && rx_frame_err) begin
        $display("FAIL pulse_excl: valid=%0b err=%0b both high", rx_data_valid, rx_frame_err);
      end else if (sbq.size() == 0) begin
        $display("FAIL unexpected_pulse: valid=%0b err=%0b data=%h, none expected",
                 rx_data_valid, rx_frame_err, rx_data_out);
      end else begin
        e = sbq.pop_front();
        if (e.err !== rx_frame_err || e.data !== rx_data_out)
          $display("FAIL pulse_match: got err=%0b data=%h want err=%0b data=%h",
                   rx_frame_err, rx_data_out, e.err, e.data);
        else pass_cnt++;
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!rx_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rx_in = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = b[i];
      wait_ticks(OS);
    end
    uart_rx_in = stop;
    wait_ticks(OS);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_t e;
    e.err = 1'b0;
    e.data = b;
    sbq.push_back(e);
  endtask

  task automatic check_drained(input string name, input int nv0, input int ne0,
                               input int dv, input int de, input logic [7:0] data);
    chk_cnt++;
    if (sbq.size() != 0 || n_valid - nv0 != dv || n_err - ne0 != de || rx_data_out !== data) begin
      $display("FAIL %s: got valid=%0d err=%0d data=%h pending=%0d want valid=%0d err=%0d data=%h pending=0",
               name, n_valid - nv0, n_err - ne0, rx_data_out, sbq.size(), dv, de, data);
      sbq.delete();
    end else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    uart_rx_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_cnt++;
    if (rx_data_out !== 8'h00 || rx_data_valid !== 1'b0 || rx_frame_err !== 1'b0)
      $display("FAIL reset_vals: got data=%h valid=%0b err=%0b want 00/0/0",
               rx_data_out, rx_data_valid, rx_frame_err);
    else pass_cnt++;
    rst_n = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_single_frame();
    int nv0 = n_valid, ne0 = n_err;
    expect_byte(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_ticks(4);
    check_drained("frame_a5", nv0, ne0, 1, 0, 8'hA5);
  endtask

  task automatic test_false_start();
    int nv0 = n_valid, ne0 = n_err;
    uart_rx_in = 1'b0;
    wait_ticks(3);
    uart_rx_in = 1'b1;
    wait_ticks(12 * OS);
    check_drained("false_start", nv0, ne0, 0, 0, 8'hA5);
  endtask

  task automatic test_frame_err();
    int nv0 = n_valid, ne0 = n_err;
    exp_t e;
    e.err = 1'b1;
    e.data = 8'hA5;
    sbq.push_back(e);
    send_frame(8'h3C, 1'b0);
    wait_ticks(40);
    uart_rx_in = 1'b1;
    wait_ticks(20);
    check_drained("frame_err_break", nv0, ne0, 0, 1, 8'hA5);
    nv0 = n_valid;
    ne0 = n_err;
    expect_byte(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_ticks(4);
    check_drained("after_break_5a", nv0, ne0, 1, 0, 8'h5A);
  endtask

  task automatic test_back_to_back();
    int nv0 = n_valid, ne0 = n_err;
    expect_byte(8'h00);
    expect_byte(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_ticks(4);
    check_drained("back_to_back", nv0, ne0, 2, 0, 8'hFF);
  endtask

  task automatic test_reset_mid_frame();
    int nv0, ne0;
    uart_rx_in = 1'b0;
    wait_ticks(OS);
    uart_rx_in = 1'b1;
    wait_ticks(OS);
    uart_rx_in = 1'b0;
    wait_ticks(OS + OS/2);
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (rx_data_out !== 8'h00 || rx_data_valid !== 1'b0 || rx_frame_err !== 1'b0)
      $display("FAIL mid_reset_vals: got data=%h valid=%0b err=%0b want 00/0/0",
               rx_data_out, rx_data_valid, rx_frame_err);
    else pass_cnt++;
    uart_rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nv0 = n_valid;
    ne0 = n_err;
    wait_ticks(12 * OS);
    check_drained("mid_reset_quiet", nv0, ne0, 0, 0, 8'h00);
    nv0 = n_valid;
    expect_byte(8'h81);
    send_frame(8'h81, 1'b1);
    wait_ticks(4);
    check_drained("after_reset_81", nv0, ne0, 1, 0, 8'h81);
  endtask

  task automatic test_glitch();
    int nv0 = n_valid, ne0 = n_err;
    expect_byte(8'h00);
    uart_rx_in = 1'b0;
    wait_ticks(4 * OS);
    // Line is high only on the tick that samples index 8 of data bit 3.
    wait_ticks(OS/2 + 1);
    uart_rx_in = 1'b1;
    wait_ticks(1);
    uart_rx_in = 1'b0;
    wait_ticks(OS/2 - 2);
    wait_ticks(4 * OS);
    uart_rx_in = 1'b1;
    wait_ticks(OS);
    wait_ticks(4);
    check_drained("glitch_00", nv0, ne0, 1, 0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_glitch();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
